instruction_memory_pipelined: RTL
=================================

// Module: instruction_memory_pipelined
// PURPOSE
//   Parametrised, pipelined instruction memory for the RISC-V 64-bit CPU family.
//   Accepts fetch requests (PC) over a valid/ready handshake, returns 32-bit instructions after a
//   configurable read latency, flags misaligned/out-of-range fetches, and provides a loader write
//   port so programs are written at run time instead of being fixed at elaboration.
//   Sits between the PC/fetch logic and decode; also serves as the fetch stage of the pipelined core.
// PARAMETERS
//   XLEN          64    PC/address width in bits.
//   ILEN          32    Instruction width in bits.
//   DEPTH_WORDS   256   Number of ILEN-bit words; power of two, >= 4.
//   READ_LATENCY  2     Cycles from request acceptance to rsp_valid; legal range 1..4.
//   BASE_ADDR     0     Byte address of word 0; must be 4-byte aligned.
// PORTS
//   clk              in   1                  Clock; all logic is rising-edge.
//   rst              in   1                  Synchronous, active-high reset.
//   req_valid        in   1                  Fetch request present.
//   req_ready        out  1                  Block can accept a request this cycle.
//   req_pc           in   XLEN               Fetch byte address.
//   rsp_valid        out  1                  Response present.
//   rsp_ready        in   1                  Consumer accepts the response.
//   rsp_pc           out  XLEN               PC of the request that produced this response.
//   rsp_instruction  out  ILEN               Fetched instruction, or NOP on fault.
//   rsp_fault        out  2                  00 none, 01 misaligned, 10 out of range.
//   load_en          in   1                  Loader write strobe.
//   load_addr        in   $clog2(DEPTH_WORDS) Word index to write.
//   load_data        in   ILEN               Word written.
// BEHAVIOUR
//   - Reset: all stage valids cleared; rsp_valid=0, rsp_pc=0, rsp_instruction=0, rsp_fault=00.
//     Memory array NOT reset. Reset mid-operation drops all in-flight requests; none are returned.
//   - Handshake: request accepted when req_valid && req_ready. Response consumed when
//     rsp_valid && rsp_ready. rsp_* hold stable while rsp_valid && !rsp_ready.
//   - Pipeline: READ_LATENCY stages, each holding {valid, pc, fault, data}.
//     stall = rsp_valid && !rsp_ready; req_ready = !stall. On stall, every stage freezes.
//     With no stall, accepted at edge t -> rsp_valid after edge t+READ_LATENCY-1 (first visible
//     at cycle t+READ_LATENCY). Throughput 1 per cycle. Pipeline bubbles move forward even during
//     stall only if the output stage is empty (no stall is asserted in that case).
//   - Address decode: word_idx = (req_pc - BASE_ADDR) >> 2.
//     Misaligned if req_pc[1:0] != 0. Out of range if req_pc < BASE_ADDR or word_idx >= DEPTH_WORDS.
//     Misaligned takes priority over out of range. On any fault: rsp_instruction = 32'h00000013
//     (NOP) and no array read is needed. Faulting requests still obey latency and ordering.
//   - Array: registered read in stage 1. Responses come back strictly in request order.
//   - Loader write: load_en writes load_data at load_addr at the clock edge. It is independent of
//     stall and handshake. A read of the same word in the same cycle returns OLD data (read-first).
//     The write is ignored while rst=1.
//   - Widths: the subtraction is XLEN-bit unsigned. A wrap (req_pc < BASE_ADDR) is treated as
//     out of range, not as an index.
// STRUCTURE
//   - Shared package riscv_pkg:
//     - NOP_INSTR = 32'h00000013
//     - fault codes FAULT_NONE / FAULT_MISALIGNED / FAULT_RANGE
//     - ILEN default
//   - Sub-module imem_array: DEPTH_WORDS x ILEN storage with a 1-cycle registered read port and a
//     read-first write port.
//   - Top module: decode, stage registers (generate loop over READ_LATENCY-1 extra stages), and
//     stall logic.
// TESTING
//   1. Load words 0..6 with a known program via the loader port, then fetch PC 0,4,...,24 back to
//      back with rsp_ready=1 -> with READ_LATENCY=2, seven responses in order, each 2 cycles after
//      its request; word 6 = 32'h406183B3, fault 00.
//   2. req_pc=64'h6 -> fault 01, instruction 32'h00000013. req_pc=64'h400 with DEPTH_WORDS=256
//      -> fault 10, NOP. req_pc=64'h402 -> fault 01 (priority).
//   3. Stream PC 0,4,8 with rsp_ready=0 for 3 cycles -> req_ready=0 while stalled and rsp held at
//      PC 0. After release, PC 0,4,8 arrive in order with no loss or duplication.
//   4. Same cycle: load_en writing word 2 = 32'hDEADBEEF and fetch PC 8 -> old word returned.
//      A fetch of PC 8 on the next cycle -> 32'hDEADBEEF.
//   5. Assert rst for 1 cycle with 2 requests in flight -> rsp_valid=0 on the next cycle, outputs
//      zero, in-flight requests never emitted. Memory contents preserved on re-fetch.
//   6. Sweep READ_LATENCY = 1, 3, 4 and BASE_ADDR = 64'h1000 -> latency matches the parameter.
//      PC 64'h1000 returns word 0; PC 64'h0FFC -> fault 10.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the fetch path.
// Fault codes, the canonical NOP and the default instruction width.
package riscv_pkg;

    localparam int ILEN_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_RANGE      = 2'b10
    } fault_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage with a registered read port and a read-first write port.
// The read register freezes when ren is low so a stalled pipe keeps its data.
module imem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen && !rst) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instruction_memory_pipelined.sv
// Pipelined instruction memory: decode, READ_LATENCY stage registers, stall.
// Faulting fetches skip the array and carry a NOP down the pipe in order.
module instruction_memory_pipelined
    import riscv_pkg::*;
#(
    parameter int             XLEN         = 64,
    parameter int             ILEN         = ILEN_DEF,
    parameter int             DEPTH_WORDS  = 256,
    parameter int             READ_LATENCY = 2,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    localparam int            AW           = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_pc,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_pc,
    output logic [ILEN-1:0] rsp_instruction,
    output logic [1:0]      rsp_fault,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [ILEN-1:0] load_data
);

    logic            stall;
    logic            mis;
    logic            rng;
    fault_t          fault_d;
    logic [XLEN-3:0] off;
    logic [AW-1:0]   widx;
    logic            ren;
    logic [ILEN-1:0] rdata;

    logic            s1_v;
    logic [XLEN-1:0] s1_pc;
    fault_t          s1_f;
    logic [ILEN-1:0] s1_d;

    logic            o_v;
    logic [XLEN-1:0] o_pc;
    fault_t          o_f;
    logic [ILEN-1:0] o_d;

    // BASE_ADDR is word aligned, so the word offset needs only bits [XLEN-1:2]
    assign off  = req_pc[XLEN-1:2] - BASE_ADDR[XLEN-1:2];
    assign widx = off[AW-1:0];
    assign mis  = |req_pc[1:0];
    assign rng  = !mis && ((req_pc < BASE_ADDR) || (|off[XLEN-3:AW]));

    always_comb begin
        fault_d = FAULT_NONE;
        unique case (1'b1)
            mis:     fault_d = FAULT_MISALIGNED;
            rng:     fault_d = FAULT_RANGE;
            default: fault_d = FAULT_NONE;
        endcase
    end

    assign stall     = o_v && !rsp_ready;
    assign req_ready = !stall;
    assign ren       = !stall && req_valid && (fault_d == FAULT_NONE);

    imem_array #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (ILEN)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .ren   (ren),
        .raddr (widx),
        .rdata (rdata),
        .wen   (load_en),
        .waddr (load_addr),
        .wdata (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_pc <= '0;
            s1_f  <= FAULT_NONE;
        end else if (!stall) begin
            s1_v  <= req_valid;
            s1_pc <= req_pc;
            s1_f  <= fault_d;
        end
    end

    assign s1_d = (s1_f == FAULT_NONE) ? rdata : ILEN'(NOP_INSTR);

    if (READ_LATENCY == 1) begin : g_l1
        assign o_v  = s1_v;
        assign o_pc = s1_pc;
        assign o_f  = s1_f;
        assign o_d  = s1_d;
    end else begin : g_ln
        localparam int NX = READ_LATENCY - 1;

        logic            xv  [NX];
        logic [XLEN-1:0] xpc [NX];
        fault_t          xf  [NX];
        logic [ILEN-1:0] xd  [NX];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < NX; i++) begin
                    xv[i]  <= 1'b0;
                    xpc[i] <= '0;
                    xf[i]  <= FAULT_NONE;
                    xd[i]  <= '0;
                end
            end else if (!stall) begin
                xv[0]  <= s1_v;
                xpc[0] <= s1_pc;
                xf[0]  <= s1_f;
                xd[0]  <= s1_d;
                for (int i = 1; i < NX; i++) begin
                    xv[i]  <= xv[i-1];
                    xpc[i] <= xpc[i-1];
                    xf[i]  <= xf[i-1];
                    xd[i]  <= xd[i-1];
                end
            end
        end

        assign o_v  = xv[NX-1];
        assign o_pc = xpc[NX-1];
        assign o_f  = xf[NX-1];
        assign o_d  = xd[NX-1];
    end

    assign rsp_valid       = o_v;
    assign rsp_pc          = o_pc;
    assign rsp_fault       = o_f;
    assign rsp_instruction = o_d;

endmodule
